// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// MDOp encoding, default latencies and counter sizing.
package md_pkg;

   localparam int MD_OP_W = 4;

   typedef logic [MD_OP_W-1:0] md_op_t;

   localparam md_op_t MD_NONE  = 4'd0;
   localparam md_op_t MD_MULT  = 4'd1;
   localparam md_op_t MD_MULTU = 4'd2;
   localparam md_op_t MD_DIV   = 4'd3;
   localparam md_op_t MD_DIVU  = 4'd4;
   localparam md_op_t MD_MTHI  = 4'd5;
   localparam md_op_t MD_MTLO  = 4'd6;
   localparam md_op_t MD_MFHI  = 4'd7;
   localparam md_op_t MD_MFLO  = 4'd8;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   // Counter must hold the longest latency and never drop below 4 bits.
   function automatic int md_cnt_w(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 4) ? 4 : w;
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/op/result bundle between execute stage and md_unit.
// master = execute-stage driver, slave = md_unit.
interface md_unit_if
   import md_pkg::*;
();

   logic [31:0] in_a;
   logic [31:0] in_b;
   md_op_t      MDOp;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   modport master (
      output in_a, in_b, MDOp, start,
      input  busy, hi, lo, md_out
   );

   modport slave (
      input  in_a, in_b, MDOp, start,
      output busy, hi, lo, md_out
   );

endinterface

// File: rtl/md_divider.sv
// Combinational 32-bit signed/unsigned divider.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module md_divider (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        is_signed,
   output logic [31:0] q,
   output logic [31:0] r,
   output logic        div_zero
);

   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] dsr;
   logic [31:0] uq;
   logic [31:0] ur;

   // 0x80000000 / -1 falls out naturally: magnitude quotient wraps back.
   always_comb begin
      neg_a    = is_signed & a[31];
      neg_b    = is_signed & b[31];
      mag_a    = neg_a ? (~a + 32'd1) : a;
      mag_b    = neg_b ? (~b + 32'd1) : b;
      div_zero = (b == 32'd0);
      dsr      = div_zero ? 32'd1 : mag_b;
      uq       = mag_a / dsr;
      ur       = mag_a % dsr;
      q        = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      r        = neg_a ? (~ur + 32'd1) : ur;
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO pair and fixed multi-cycle latency.
// Define MD_UNIT_DIV_EN to build the divider (div/divu); otherwise they act as none.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic    clk,
   input  logic    reset,
   md_unit_if.slave md
);

   localparam int MAX_CYC =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = md_cnt_w(MAX_CYC);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } md_state_t;

   md_state_t   state;
   logic [CW-1:0] cnt;
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_we;

   logic        is_signed;
   logic        go_mul;
   logic        go_div;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_zero;

   always_comb begin
      is_signed = (md.MDOp == MD_MULT) || (md.MDOp == MD_DIV);
      go_mul    = md.start &&
                  ((md.MDOp == MD_MULT) || (md.MDOp == MD_MULTU));
`ifdef MD_UNIT_DIV_EN
      go_div    = md.start &&
                  ((md.MDOp == MD_DIV) || (md.MDOp == MD_DIVU));
`else
      go_div    = 1'b0;
`endif
   end

   // One 64x64 multiplier covers both signednesses via the extension.
   always_comb begin
      ext_a = {{32{is_signed & md.in_a[31]}}, md.in_a};
      ext_b = {{32{is_signed & md.in_b[31]}}, md.in_b};
      prod  = ext_a * ext_b;
   end

`ifdef MD_UNIT_DIV_EN
   md_divider u_div (
      .a        (md.in_a),
      .b        (md.in_b),
      .is_signed(is_signed),
      .q        (div_q),
      .r        (div_r),
      .div_zero (div_zero)
   );
`else
   assign div_q    = 32'd0;
   assign div_r    = 32'd0;
   assign div_zero = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         busy_q <= 1'b0;
         cnt    <= '0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         res_we <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (go_mul) begin
                  res_hi <= prod[63:32];
                  res_lo <= prod[31:0];
                  res_we <= 1'b1;
                  cnt    <= CW'(MULT_CYCLES);
                  busy_q <= 1'b1;
                  state  <= ST_BUSY;
               end else if (go_div) begin
                  res_hi <= div_r;
                  res_lo <= div_q;
                  // Zero divisor still burns the full latency.
                  res_we <= ~div_zero;
                  cnt    <= CW'(DIV_CYCLES);
                  busy_q <= 1'b1;
                  state  <= ST_BUSY;
               end else if (md.MDOp == MD_MTHI) begin
                  hi_q <= md.in_a;
               end else if (md.MDOp == MD_MTLO) begin
                  lo_q <= md.in_a;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (res_we) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      unique case (md.MDOp)
         MD_MFHI: md.md_out = hi_q;
         MD_MFLO: md.md_out = lo_q;
         default: md.md_out = 32'd0;
      endcase
   end

   assign md.busy = busy_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random ops vs an arithmetic model.
// Follows MD_UNIT_DIV_EN to pick div/divu expectations.
module tb_md_unit;
   import md_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   md_unit_if md ();

   md_unit #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .md   (md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_we;
   int          m_rem;

`ifdef MD_UNIT_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] model_out();
      case (md.MDOp)
         MD_MFHI: return m_hi;
         MD_MFLO: return m_lo;
         default: return 32'd0;
      endcase
   endfunction

   function automatic void model_edge();
      longint p, sa, sb;
      if (rst) begin
         m_hi = 0; m_lo = 0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && m_we) begin
            m_hi = m_phi; m_lo = m_plo;
         end
      end else begin
         case (md.MDOp)
            MD_MULT, MD_MULTU: if (md.start) begin
               if (md.MDOp == MD_MULT) begin
                  sa = longint'($signed(md.in_a));
                  sb = longint'($signed(md.in_b));
               end else begin
                  sa = longint'(md.in_a);
                  sb = longint'(md.in_b);
               end
               p = sa * sb;
               m_phi = p[63:32]; m_plo = p[31:0];
               m_we = 1; m_rem = MC;
            end
            MD_DIV, MD_DIVU: if (md.start && DIV_ON) begin
               if (md.MDOp == MD_DIV) begin
                  sa = longint'($signed(md.in_a));
                  sb = longint'($signed(md.in_b));
               end else begin
                  sa = longint'(md.in_a);
                  sb = longint'(md.in_b);
               end
               m_we = (sb != 0);
               if (m_we) begin
                  p = sa / sb; m_plo = p[31:0];
                  p = sa % sb; m_phi = p[31:0];
               end
               m_rem = DC;
            end
            MD_MTHI: m_hi = md.in_a;
            MD_MTLO: m_lo = md.in_a;
            default: ;
         endcase
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check("busy", {31'd0, md.busy}, {31'd0, m_rem != 0});
      check("hi", md.hi, m_hi);
      check("lo", md.lo, m_lo);
      check("md_out", md.md_out, model_out());
   endtask

   task automatic set_in(input md_op_t op, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
      md.MDOp = op; md.start = s; md.in_a = a; md.in_b = b;
   endtask

   // Issue one op, then idle until busy drops (bounded) and check latency.
   task automatic run_op(input string tag, input md_op_t op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat);
      int nb;
      set_in(op, 1'b1, a, b);
      tick();
      set_in(MD_NONE, 1'b0, 32'd0, 32'd0);
      nb = 0;
      while (md.busy && nb < 40) begin
         nb++;
         tick();
      end
      check({tag, "_lat"}, nb, exp_lat);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] ph, pl;
      n_chk = 0; n_pass = 0;
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_we = 0; m_rem = 0;
      rst = 1'b1;
      set_in(MD_NONE, 1'b0, 32'd0, 32'd0);
      tick();
      tick();
      check("rst_hi", md.hi, 32'd0);
      check("rst_lo", md.lo, 32'd0);
      rst = 1'b0;

      run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MC);
      check("mult_hi", md.hi, 32'hFFFF_FFFF);
      check("mult_lo", md.lo, 32'hFFFF_FFFA);

      run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MC);
      check("multu_hi", md.hi, 32'd1);
      check("multu_lo", md.lo, 32'hFFFF_FFFE);

      run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_ON ? DC : 0);
      check("div_hi", md.hi, DIV_ON ? 32'hFFFF_FFFF : 32'd1);
      check("div_lo", md.lo, DIV_ON ? 32'hFFFF_FFFD : 32'hFFFF_FFFE);

      run_op("ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_ON ? DC : 0);
      ph = DIV_ON ? 32'd0 : 32'd1;
      pl = DIV_ON ? 32'h8000_0000 : 32'hFFFF_FFFE;
      check("ovf_hi", md.hi, ph);
      check("ovf_lo", md.lo, pl);

      run_op("divz", MD_DIVU, 32'd5, 32'd0, DIV_ON ? DC : 0);
      check("divz_hi", md.hi, ph);
      check("divz_lo", md.lo, pl);

      // mthi and a second start while busy must both be dropped
      set_in(MD_MULT, 1'b1, 32'd3, 32'd4);
      tick();
      set_in(MD_MTHI, 1'b0, 32'h1234, 32'd0);
      tick();
      set_in(MD_MULT, 1'b1, 32'd7, 32'd7);
      tick();
      set_in(MD_NONE, 1'b0, 32'd0, 32'd0);
      repeat (MC) tick();
      check("ign_busy", {31'd0, md.busy}, 32'd0);
      check("ign_hi", md.hi, 32'd0);
      check("ign_lo", md.lo, 32'd12);

      set_in(MD_MTHI, 1'b0, 32'h55, 32'd0);
      tick();
      set_in(MD_MTLO, 1'b0, 32'hABCD, 32'd0);
      tick();
      md.MDOp = MD_MFLO;
      #1 check("mflo", md.md_out, 32'hABCD);
      md.MDOp = MD_MFHI;
      #1 check("mfhi", md.md_out, 32'h55);
      md.MDOp = MD_NONE;
      #1 check("mfnone", md.md_out, 32'd0);

      // reset in the third busy cycle discards the op
      set_in(DIV_ON ? MD_DIV : MD_MULT, 1'b1, 32'd100, 32'd7);
      tick();
      set_in(MD_NONE, 1'b0, 32'd0, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy", {31'd0, md.busy}, 32'd0);
      check("mid_rst_hi", md.hi, 32'd0);
      check("mid_rst_lo", md.lo, 32'd0);
      repeat (DC + 2) tick();
      check("no_late_lo", md.lo, 32'd0);

      if (!DIV_ON) begin
         set_in(MD_DIV, 1'b1, 32'd9, 32'd3);
         tick();
         check("nodiv_busy", {31'd0, md.busy}, 32'd0);
      end

      repeat (3000) begin
         rst = ($urandom_range(0, 299) == 0);
         set_in(md_op_t'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), rnd_val(), rnd_val());
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit sitting beside the ALU in the execute stage of the datapath. It consumes the same register-file operands the ALU consumes (rs/rt read data). It owns the HI/LO register pair and executes mult/multu/div/divu over a fixed multi-cycle latency, plus mthi/mtlo/mfhi/mflo. Its read result feeds the write-back mux as an extra source alongside ALU result, DM read data and PC+4.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_a  input  32  rs read data (dividend / multiplicand / mthi, mtlo source)
- in_b  input  32  rt read data (divisor / multiplier)
- MDOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 behave as none
- start  input  1  qualifies MDOp 1–4 this cycle
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- md_out  output  32  combinational: hi when MDOp=7, lo when MDOp=8, else 0

## Operation
- State: hi, lo, busy, down-counter cnt (4 bits minimum, sized for max(MULT_CYCLES, DIV_CYCLES)), pending result regs res_hi/res_lo.
- Reset: hi=0, lo=0, busy=0, cnt=0, res_hi=res_lo=0.
- Idle (busy=0) with start=1 and MDOp in 1–4: compute result from in_a/in_b into res_hi/res_lo, load cnt with MULT_CYCLES or DIV_CYCLES, set busy.
- mult: signed 32×32→64; hi=product[63:32], lo=product[31:0]. multu: same, unsigned.
- div: signed; lo=quotient truncated toward zero, hi=remainder with dividend's sign. 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. divu: unsigned.
- Divisor zero (div/divu): op still runs full DIV_CYCLES with busy asserted; hi/lo left unchanged at completion.
- Busy: cnt decrements each cycle; on the edge where cnt==1, hi←res_hi, lo←res_lo, busy←0.
- start while busy=1: ignored. The hazard unit stalls on busy|start; the block does not queue.
- mthi/mtlo (MDOp 5/6, start irrelevant) while idle: hi or lo ← in_a at the edge. While busy: ignored. Completion always wins.
- mfhi/mflo: pure read via md_out. Legal during busy and returns the current (old) hi/lo; stalling is the hazard unit's duty.
- start=1 with MDOp outside 1–4: no effect beyond ops 5–8.

## Timing
- start sampled at edge ending cycle T → busy=1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES) → new hi/lo visible and busy=0 in cycle T+N+1.
- Back-to-back: start accepted again in cycle T+N+1.
- mthi/mtlo in cycle T → new value visible in T+1.
- md_out: zero latency from MDOp and hi/lo.
- Reset asserted mid-operation: in-flight op discarded; next cycle busy=0, hi=lo=0.

## Configuration
- MD_UNIT_DIV_EN defined: div/divu implemented as above.
- Undefined: no divider logic. MDOp 3/4 with start behave as none: busy stays 0 and hi/lo are unchanged. DIV_CYCLES is unused.

## Structure
- Shared package md_pkg: MDOp encoding constants (MD_NONE…MD_MFLO), default MULT_CYCLES/DIV_CYCLES, MDOp width.
- One sub-module, md_divider: combinational signed/unsigned quotient/remainder with the overflow and zero-divisor rules. Instantiated only under MD_UNIT_DIV_EN.
- The multiply product and the counter/FSM stay in md_unit.

## Test plan
- mult in_a=0xFFFFFFFE (−2), in_b=3, start at T → busy high T+1…T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu in_a=0xFFFFFFFF, in_b=2 → after 5 busy cycles hi=1, lo=0xFFFFFFFE.
- div in_a=−7, in_b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. Then divu 5/0 → hi/lo unchanged.
- mthi 0x1234 during busy, plus a second start during busy → both ignored; final hi/lo equal the first op's result.
- mtlo 0xABCD idle, then MDOp=8 → md_out=0xABCD next cycle. MDOp=7 returns hi; MDOp=0 returns 0.
- reset in cycle T+3 of a div → busy=0, hi=lo=0 the next cycle, and no late writeback afterwards. Without MD_UNIT_DIV_EN, div with start → busy never asserts.
